// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg
//   Shared constants for the instruction memory loader: data widths, the
//   default program start address, the default word-count limit and the
//   loader state encoding.
//   Optional feature macro used by the loader: INSTR_LOADER_CHECKSUM_EN
//   (enables the CHK state and the 4-byte trailer).
package instr_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0020;
    localparam int          DEFAULT_MAX_WORDS = 256;

    // Loader states. A plain 3-bit encoding keeps older tools happy.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    // True in the states that consume stream bytes.
    function automatic logic is_loading(input logic [2:0] st);
        return (st == ST_HDR) || (st == ST_DATA) || (st == ST_CHK);
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_word_assembler.sv
// byte_word_assembler
//   Packs a big-endian byte stream into 32-bit words. The first byte of a
//   word lands in bits [31:24]. word_valid_o pulses combinationally in the
//   cycle the 4th byte is offered, with word_o already holding that byte.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     clear_i       : drop any partial word (start of a new load)
//     byte_valid_i  : byte_i is consumed this cycle
//     byte_i        : stream byte
//     word_o        : assembled word (valid when word_valid_o)
//     word_valid_o  : one-cycle pulse on the 4th byte of a word
module byte_word_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    // Only the three older bytes need storage; the newest byte is taken
    // straight from the input so the word is complete on the 4th byte.
    logic [WORD_W-BYTE_W-1:0] shift_q;
    logic [1:0]               byte_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            byte_cnt_q <= 2'd0;
        end else if (clear_i) begin
            shift_q    <= '0;
            byte_cnt_q <= 2'd0;
        end else if (byte_valid_i) begin
            shift_q    <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
            byte_cnt_q <= byte_cnt_q + 2'd1;   // wraps 3 -> 0
        end
    end

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Boot-time writer for the instruction memory. Receives a big-endian byte
//   stream (4-byte word count N, then N instruction words) and writes each
//   word to consecutive word addresses starting at BASE_ADDR.
//   Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a 4-byte
//   trailer equal to the wrapping 32-bit sum of the N data words.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     load_start     : pulse; starts a load from IDLE, DONE or ERR
//     in_valid/in_data/in_ready : byte stream handshake
//     wr_en/wr_addr/wr_data     : instruction memory write port
//     busy           : load in progress
//     done, error    : level status of the last load
//     words_written  : words written by the current/last load
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS   // must fit in 16 bits
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_END = ST_CHK;
`else
    localparam logic [2:0] ST_END = ST_DONE;
`endif

    logic [2:0]  state_q, state_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [15:0] words_written_q, words_written_d;
    logic [15:0] n_words_q, n_words_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        start;
    logic        byte_accept;
    logic [31:0] asm_word;
    logic        asm_word_valid;

    assign in_ready    = is_loading(state_q);
    assign byte_accept = in_valid && in_ready;
    assign start       = load_start &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

    byte_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start),
        .byte_valid_i (byte_accept),
        .byte_i       (in_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d         = state_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        words_written_d = words_written_q;
        n_words_d       = n_words_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d           = sum_q;
`endif
        if (start) begin
            state_d         = ST_HDR;
            wr_addr_d       = BASE_ADDR;
            words_written_d = 16'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_d           = 32'd0;
`endif
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (asm_word_valid) begin
                        if (asm_word > 32'(MAX_WORDS)) begin
                            state_d = ST_ERR;
                        end else if (asm_word == 32'd0) begin
                            state_d = ST_END;
                        end else begin
                            n_words_d = asm_word[15:0];
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // The cycle after a strobe: move the address on and
                    // leave DATA once the last word has been written.
                    if (wr_en_q) begin
                        wr_addr_d       = wr_addr_q + 32'd4;
                        words_written_d = words_written_q + 16'd1;
                        if (words_written_q + 16'd1 == n_words_q) begin
                            state_d = ST_END;
                        end
                    end
                    if (asm_word_valid) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = asm_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        sum_d     = sum_q + asm_word;
`endif
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (asm_word_valid) begin
                        state_d = (asm_word == sum_q) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= BASE_ADDR;
            wr_data_q       <= 32'd0;
            words_written_q <= 16'd0;
            n_words_q       <= 16'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q           <= 32'd0;
`endif
        end else begin
            state_q         <= state_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            words_written_q <= words_written_d;
            n_words_q       <= n_words_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q           <= sum_d;
`endif
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = in_ready;
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign words_written = words_written_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream from a host/boot link and writes assembled 32-bit MIPS instructions into the instruction memory write port, starting at PROGRAM_START.
- Sits between the boot byte link and instr_memory; the fetch stage reads what this block wrote.
- Stream format, big-endian: 4-byte header (word count N), then N instruction words.

Parameters:
- BASE_ADDR, 32'h00400020, byte address of the first instruction written.
- MAX_WORDS, 256, largest accepted N; N > MAX_WORDS is an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR
- in_valid  in  1  byte valid
- in_data  in  8  stream byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  32  byte address, word aligned
- wr_data  out  32  instruction word
- busy  out  1  high in HDR/DATA (and CHK)
- done  out  1  level; high in DONE
- error  out  1  level; high in ERR
- words_written  out  16  count of words written this load

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, wr_en, busy, done, error = 0; wr_addr = BASE_ADDR; wr_data = 0; words_written = 0; byte_cnt = 0.
- States: IDLE, HDR, DATA, CHK (macro only), DONE, ERR.
- IDLE/DONE/ERR + load_start -> HDR. Clears done, error, words_written and byte_cnt. wr_addr = BASE_ADDR.
- in_ready = 1 exactly in HDR, DATA and CHK. The block never backpressures mid-load. Bytes offered in other states are not consumed.
- Assembly: shift register, first byte -> bits [31:24]. A 2-bit byte_cnt wraps 3 -> 0 on the 4th accepted byte.
- HDR, 4th byte accepted at edge t:
  - N = assembled word.
  - N > MAX_WORDS -> ERR at t+1.
  - N == 0 -> DONE at t+1, or CHK when the macro is defined.
  - Otherwise -> DATA.
- DATA, 4th byte accepted at edge t:
  - At t+1: wr_en = 1 for exactly one cycle, wr_data = word, wr_addr = BASE_ADDR + 4*words_written (pre-increment value).
  - wr_addr then advances by 4 and words_written increments.
  - Latency: 1 cycle from last byte to write.
- After the N-th write strobe, state -> DONE (or CHK). Back-to-back bytes at full rate are legal, giving one write every 4 cycles.
- Invalid cycles between bytes are allowed and leave the partial word intact.
- load_start while busy: ignored; the load continues.
- rst_n asserted mid-load: immediate return to reset values. The partial word is discarded; words already written stay in memory.
- wr_addr wraps modulo 2^32. Not reachable with MAX_WORDS ≤ 65535.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or after the header if N=0), state CHK accepts a 4-byte trailer.
  - Trailer must equal the 32-bit wrapping sum of all N data words. The header is excluded.
  - Match -> DONE. Mismatch -> ERR. Memory writes already done are not undone.
- Not defined: no CHK state, no trailer. Any extra bytes are not accepted (in_ready=0 in DONE).

Decomposition:
- Package instr_loader_pkg: state encoding localparams (IDLE, HDR, DATA, CHK, DONE, ERR), default BASE_ADDR 32'h00400020, byte/word width constants.
- One sub-module: byte_word_assembler (shift register + byte_cnt, outputs word and word_valid pulse), instanced once and reused for header, data and trailer.

Test Plan:
- Load N=2 with bytes 00 00 00 02 24 08 00 01 24 09 00 02 -> wr_en pulses: (0x00400020, 0x24080001), (0x00400024, 0x24090002); done=1, words_written=2, error=0.
- Load N=8 using words 24080001, 24090002, 24020001, 01292020, 0000000C, 2402000A, 00000000, 0000000C with random in_valid gaps -> same data at 0x00400020..0x0040003C; readback through instr_memory matches each word.
- Header 00 00 01 01 (257 > MAX_WORDS) -> error=1, no wr_en, in_ready=0 afterwards; a new load_start then recovers.
- Header N=0 -> done one cycle after the 4th header byte, no writes (checksum build: trailer 00000000 required).
- rst_n low after 6 bytes of an N=2 load -> all outputs at reset values; a fresh load then writes from 0x00400020 correctly.
- Checksum build, N=2 as in the first scenario with trailer 48 11 00 03 -> done. With trailer 48 11 00 04 -> error=1 after both writes.
